// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write arbiter and its round-robin picker.
// Holds the arbiter state encoding and the width of the optional per-requester beat counters.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int NUM_REQ_DEF   = 4;
    localparam int DATA_W_DEF    = 4;
    localparam int MAX_BURST_DEF = 4;

    localparam int STAT_W = 8;

endpackage

// File: rtl/fifo_arb_rr_pick.sv
// Combinational round-robin search: the first requester with req high, starting after last_owner.
// Zero latency, no state; any_req flags that the returned owner is meaningful.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_owner,
    output logic [ID_W-1:0]    owner,
    output logic               any_req
);

    // idx[k] is the requester examined k places after last_owner, wrapping modulo NUM_REQ.
    logic [ID_W-1:0] idx [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            idx[k] = ID_W'((int'(last_owner) + 1 + k) % NUM_REQ);
        end
    end

    // Scan from the farthest position back to the nearest so the nearest hit wins.
    always_comb begin
        owner   = '0;
        any_req = |req;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[idx[i]]) begin
                owner = idx[i];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port; 1-cycle grant latency, ack same cycle as write.
// Stalls (no ack, burst held) while fifo_full; FIFO_ARB_STATS_EN adds per-requester saturating beat counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = NUM_REQ_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = MAX_BURST_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          ack,
    input  logic                        fifo_full,
    output logic                        fifo_wr_en,
    output logic [DATA_W-1:0]           fifo_data_in,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        busy
`ifdef FIFO_ARB_STATS_EN
    ,
    input  logic                        stat_clr,
    output logic [NUM_REQ*STAT_W-1:0]   stat_cnt
`endif
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    arb_state_t      state_q, state_d;
    logic [ID_W-1:0] owner_q, owner_d;
    logic [ID_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [ID_W-1:0] pick_owner;
    logic            any_req;
    logic            owner_req;
    logic            beat;

    logic [DATA_W-1:0] slice [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
        assign slice[g] = req_data[g*DATA_W +: DATA_W];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req        (req),
        .last_owner (last_q),
        .owner      (pick_owner),
        .any_req    (any_req)
    );

    // last_q resets to the highest index so requester 0 is searched first.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    assign owner_req = req[owner_q];
    assign beat      = (state_q == BURST) && owner_req && !fifo_full;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d = pick_owner;
                    state_d = BURST;
                end
            end
            BURST: begin
                // A dropped req closes the burst even under fifo_full; a full FIFO alone only holds it.
                if (!owner_req) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                    cnt_d   = '0;
                end else if (beat) begin
                    if (cnt_q == LAST_BEAT) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        ack          = '0;
        busy         = (state_q == BURST);
        fifo_wr_en   = beat;
        fifo_data_in = '0;
        grant_id     = '0;
        if (busy) begin
            ack[owner_q] = beat;
            fifo_data_in = slice[owner_q];
            grant_id     = owner_q;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
        logic [STAT_W-1:0] cnt;

        // Clear takes priority over a same-cycle ack; the count sticks at all-ones.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt <= '0;
            end else if (stat_clr) begin
                cnt <= '0;
            end else if (ack[g] && (cnt != {STAT_W{1'b1}})) begin
                cnt <= cnt + 1'b1;
            end
        end

        assign stat_cnt[g*STAT_W +: STAT_W] = cnt;
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter at default sizing (4 requesters, 4-bit beats, 4-beat bursts).
// Inputs change 1 time unit after the rising edge; outputs are compared on the falling edge.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] req_data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_wr_en;
    logic [3:0]  fifo_data_in;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef FIFO_ARB_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_cnt;
`endif

    int errors = 0;
    int checks = 0;

    logic [11:0] obs;
    logic [11:0] exp;
    assign obs = {busy, grant_id, ack, fifo_wr_en, fifo_data_in};

    fifo_wr_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .ack          (ack),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_id     (grant_id),
        .busy         (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stat_clr     (stat_clr),
        .stat_cnt     (stat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    task automatic do_reset();
        reset     = 1'b0;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        req       = 4'b1111;
        req_data  = 16'hFFFF;
        fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        exp = '0;
        if (obs !== exp) begin errors++; $display("FAIL reset_hold got=%h exp=%h", obs, exp); end
        checks++;
        req = '0;
        reset = 1'b1;
        @(negedge clk);
        if (obs !== exp) begin errors++; $display("FAIL reset_release got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_single_req();
        do_reset();
        req      = 4'b0100;
        req_data = 16'h0500;
        @(negedge clk);
        exp = '0;
        if (obs !== exp) begin errors++; $display("FAIL single_arb got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            exp = {1'b1, 2'd2, 4'b0100, 1'b1, 4'(5 + k)};
            if (obs !== exp) begin errors++; $display("FAIL single_beat%0d got=%h exp=%h", k, obs, exp); end
            checks++;
            @(posedge clk); #1;
            req_data[11:8] = 4'(6 + k);
        end
        req = '0;
        @(negedge clk);
        exp = {1'b1, 2'd2, 4'b0000, 1'b0, 4'h8};
        if (obs !== exp) begin errors++; $display("FAIL single_exit got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        @(negedge clk);
        exp = '0;
        if (obs !== exp) begin errors++; $display("FAIL single_idle got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_round_robin();
        int g;
        do_reset();
        req      = 4'b1111;
        req_data = 16'hBA98;
        for (int b = 0; b < 5; b++) begin
            g = b % 4;
            @(negedge clk);
            exp = '0;
            if (obs !== exp) begin errors++; $display("FAIL rr_gap%0d got=%h exp=%h", b, obs, exp); end
            checks++;
            @(posedge clk); #1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                exp = {1'b1, 2'(g), 4'(1 << g), 1'b1, 4'(8 + g)};
                if (obs !== exp) begin errors++; $display("FAIL rr_burst%0d_beat%0d got=%h exp=%h", b, k, obs, exp); end
                checks++;
                @(posedge clk); #1;
            end
        end
        req = '0;
        @(posedge clk); #1;
    endtask

    task automatic test_fifo_full();
        do_reset();
        req      = 4'b0010;
        req_data = 16'h00C0;
        @(negedge clk);
        @(posedge clk); #1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp = {1'b1, 2'd1, 4'b0010, 1'b1, 4'hC};
            if (obs !== exp) begin errors++; $display("FAIL full_pre%0d got=%h exp=%h", k, obs, exp); end
            checks++;
            @(posedge clk); #1;
        end
        fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            exp = {1'b1, 2'd1, 4'b0000, 1'b0, 4'hC};
            if (obs !== exp) begin errors++; $display("FAIL full_stall%0d got=%h exp=%h", k, obs, exp); end
            checks++;
            @(posedge clk); #1;
        end
        fifo_full = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            exp = {1'b1, 2'd1, 4'b0010, 1'b1, 4'hC};
            if (obs !== exp) begin errors++; $display("FAIL full_post%0d got=%h exp=%h", k, obs, exp); end
            checks++;
            @(posedge clk); #1;
        end
        req = '0;
        @(negedge clk);
        exp = '0;
        if (obs !== exp) begin errors++; $display("FAIL full_burst_len got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
    endtask

    task automatic test_early_drop();
        do_reset();
        req      = 4'b1001;
        req_data = 16'hE003;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        exp = {1'b1, 2'd0, 4'b0001, 1'b1, 4'h3};
        if (obs !== exp) begin errors++; $display("FAIL drop_beat0 got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        req_data[3:0] = 4'h7;
        @(negedge clk);
        exp = {1'b1, 2'd0, 4'b0001, 1'b1, 4'h7};
        if (obs !== exp) begin errors++; $display("FAIL drop_beat1 got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        req = 4'b1000;
        @(negedge clk);
        exp = {1'b1, 2'd0, 4'b0000, 1'b0, 4'h7};
        if (obs !== exp) begin errors++; $display("FAIL drop_exit got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        @(negedge clk);
        exp = '0;
        if (obs !== exp) begin errors++; $display("FAIL drop_idle got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        @(negedge clk);
        exp = {1'b1, 2'd3, 4'b1000, 1'b1, 4'hE};
        if (obs !== exp) begin errors++; $display("FAIL drop_next_grant got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req      = 4'b0010;
        req_data = 16'h0062;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        exp = {1'b1, 2'd1, 4'b0010, 1'b1, 4'h6};
        if (obs !== exp) begin errors++; $display("FAIL rstmid_beat got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        exp = '0;
        if (obs !== exp) begin errors++; $display("FAIL rstmid_immediate got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        reset = 1'b1;
        req   = 4'b0011;
        @(negedge clk);
        if (obs !== exp) begin errors++; $display("FAIL rstmid_idle got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        @(negedge clk);
        exp = {1'b1, 2'd0, 4'b0001, 1'b1, 4'h2};
        if (obs !== exp) begin errors++; $display("FAIL rstmid_first_grant got=%h exp=%h", obs, exp); end
        checks++;
        @(posedge clk); #1;
        req = '0;
        repeat (2) @(posedge clk);
        #1;
    endtask

`ifdef FIFO_ARB_STATS_EN
    task automatic test_stats();
        do_reset();
        @(negedge clk);
        if (stat_cnt !== 32'h0) begin errors++; $display("FAIL stats_reset got=%h exp=%h", stat_cnt, 32'h0); end
        checks++;
        @(posedge clk); #1;
        req      = 4'b0100;
        req_data = 16'h0900;
        repeat (5) @(posedge clk);
        #1;
        if (stat_cnt !== 32'h0004_0000) begin errors++; $display("FAIL stats_first_burst got=%h exp=%h", stat_cnt, 32'h0004_0000); end
        checks++;
        repeat (395) @(posedge clk);
        #1 req = '0;
        repeat (2) @(posedge clk);
        #1;
        if (stat_cnt !== 32'h00FF_0000) begin errors++; $display("FAIL stats_saturate got=%h exp=%h", stat_cnt, 32'h00FF_0000); end
        checks++;
        stat_clr = 1'b1;
        @(posedge clk); #1;
        stat_clr = 1'b0;
        if (stat_cnt !== 32'h0) begin errors++; $display("FAIL stats_clear got=%h exp=%h", stat_cnt, 32'h0); end
        checks++;
    endtask
`endif

    initial begin
        reset     = 1'b0;
        req       = '0;
        req_data  = '0;
        fifo_full = 1'b0;
`ifdef FIFO_ARB_STATS_EN
        stat_clr  = 1'b0;
`endif
        test_reset();
        test_single_req();
        test_round_robin();
        test_fifo_full();
        test_early_drop();
        test_reset_mid_burst();
`ifdef FIFO_ARB_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one sync_fifo write port among NUM_REQ producers.
- Grants one producer at a time for a burst of up to MAX_BURST beats.
- Drives the FIFO wr_en/data_in and stalls on the FIFO full flag.
- Sits between the producer blocks and the FIFO; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 4, beat width; equals the FIFO data width.
- MAX_BURST, 4, maximum beats per grant (1..15).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- req  in  NUM_REQ  per-requester "has a beat"; must stay high until acked.
- req_data  in  NUM_REQ*DATA_W  requester i's beat in slice [i*DATA_W +: DATA_W].
- ack  out  NUM_REQ  one-hot; beat of requester i accepted this cycle.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_data_in  out  DATA_W  FIFO write data.
- grant_id  out  $clog2(NUM_REQ)  current owner; valid while busy=1.
- busy  out  1  high in state BURST.

Behaviour:
- Reset values: state IDLE, last_owner = NUM_REQ-1 (requester 0 has first priority), beat_cnt = 0, grant_id = 0. Outputs are low/zero while in reset and in IDLE.
- The reset clears state immediately on assertion and is released synchronously to clk via the standard reset synchronizer upstream.
- IDLE:
  - If any req is high, register owner = first requester with req high, searching from last_owner+1 with modulo NUM_REQ wrap; go to BURST. This gives 1 cycle of arbitration latency.
  - If no req is high, stay in IDLE.
- BURST:
  - beat = req[owner] && !fifo_full.
  - fifo_wr_en = beat. ack[owner] = beat (combinational, same cycle). fifo_data_in = req_data slice of owner; it is driven with the owner's slice even when beat=0.
  - beat_cnt increments on each beat.
- Exit BURST to IDLE, setting last_owner = owner and beat_cnt = 0, when either condition holds:
  - a beat occurs with beat_cnt == MAX_BURST-1; or
  - req[owner] is low; this cycle produces no beat.
- fifo_full in BURST: no beat, no ack, stay in BURST, beat_cnt held. A full FIFO never ends a burst by itself.
- Requesters other than the owner never see ack. A non-owner req change does nothing until the next IDLE.
- Fairness: with all requesters active, grants rotate 0,1,2,...,NUM_REQ-1,0. A requester waits at most (NUM_REQ-1)*(MAX_BURST+1) cycles of granted bandwidth.
- A requester may drop req only after its ack. Dropping req earlier is a protocol error; the arbiter ends the burst cleanly.
- Reset mid-burst: the beat is lost, and the FIFO write is not issued that cycle.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined: adds output stat_cnt [NUM_REQ*8], a per-requester 8-bit beat counter.
  - Increments on that requester's ack and saturates at 255.
  - Cleared by reset.
  - Adds input stat_clr (1 bit), a synchronous clear of all counters. Clear wins over a same-cycle increment.
- Undefined: neither port exists and no counter logic is present.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef arb_state_t enum {IDLE, BURST};
  - localparam defaults NUM_REQ_DEF, DATA_W_DEF, MAX_BURST_DEF;
  - the stats counter width constant.
- One sub-module, rr_pick: combinational round-robin priority search taking req and last_owner, returning owner and any_req. It is reusable by a future read-side scheduler.

Test Plan:
- Only req[2] high, 3 beats, FIFO empty: grant_id=2 one cycle after req; ack[2] and fifo_wr_en on 3 consecutive cycles; then IDLE.
- All 4 req high continuously, MAX_BURST=4: grant order 0,1,2,3,0; exactly 4 beats each; one idle cycle between bursts.
- Owner 1 mid-burst, fifo_full high for 5 cycles: no ack and no wr_en for those 5 cycles; burst resumes with beat_cnt intact and completes all 4 beats.
- req[0] drops after 2 beats while req[3] is high: burst ends; next grant is 3; the FIFO receives exactly the 2 beats of requester 0, in order.
- Reset asserted mid-burst: outputs zero immediately; after release, req[1] and req[0] both high gives grant to 0 first.
- FIFO_ARB_STATS_EN defined: 300 beats from requester 2 gives stat_cnt[2]=255; stat_clr pulse gives 0.
